// File: rtl/port_rst_sched_pkg.sv
// -----------------------------------------------------------------------------
// rst_pkg
//   Shared definitions for the reset-sequencing blocks: the one-hot sequencer
//   state encoding (also used by the global reset controller) and the default
//   hold/settle timing and counter width.
// -----------------------------------------------------------------------------
package rst_pkg;

  // One-hot sequencer states. The values are fixed so that any block that
  // decodes them (status registers, the global controller) sees the same bits.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_HOLD   = 4'b0010,
    ST_SETTLE = 4'b0100,
    ST_DONE   = 4'b1000
  } rst_state_e;

  // Default timing, in sys_clk cycles, and width of the shared cycle counter.
  localparam int DEF_HOLD_CYC   = 64;
  localparam int DEF_SETTLE_CYC = 128;
  localparam int DEF_CW         = 8;

endpackage : rst_pkg

// File: rtl/port_rst_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. Searches the pending vector
//   starting at rr_ptr and wrapping, and returns the first set position.
//
//   Ports:
//     pending   in  [N-1:0]  request vector
//     rr_ptr    in  [IW-1:0] index searched first (must be < N)
//     gnt_valid out          at least one pending bit is set
//     gnt_idx   out [IW-1:0] selected index (0 when gnt_valid is low)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] rr_ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // cand_idx[k] is the port examined k-th in the search order for this rr_ptr.
  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand_idx[gi] = IW'((32'(rr_ptr) + 32'(gi)) % 32'(N));
      assign cand_hit[gi] = pending[cand_idx[gi]];
    end
  endgenerate

  // Walk from the last candidate down to the first so the earliest hit in
  // search order is the one that survives.
  always_comb begin
    gnt_valid = |cand_hit;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        gnt_idx = cand_idx[k];
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/port_rst_sched.sv
// -----------------------------------------------------------------------------
// port_rst_sched
//   Per-port soft-reset scheduler. Latches one-cycle reset requests from NPORT
//   requesters, grants them round-robin one port at a time, drives that port's
//   active-low reset for HOLD_CYC cycles, waits SETTLE_CYC cycles, then pulses
//   the port's ack. Port soft resets are therefore never overlapped.
//
//   Ports:
//     sys_clk    in            clock
//     arstn      in            asynchronous active-low reset
//     sys_ready  in            global reset released; gates new grants and
//                              aborts a running sequence when it falls
//     req        in  [NPORT]   per-port one-cycle request pulses
//     rstn_port  out [NPORT]   registered active-low per-port soft resets
//     ack        out [NPORT]   one-cycle completion pulse per port
//     busy       out           sequence in HOLD/SETTLE/DONE
//     cur_port   out [PW]      port being serviced (valid while busy)
// -----------------------------------------------------------------------------
module port_rst_sched
  import rst_pkg::*;
#(
  parameter int NPORT      = 4,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CW         = DEF_CW,
  parameter int PW         = $clog2(NPORT)
) (
  input  logic             sys_clk,
  input  logic             arstn,
  input  logic             sys_ready,
  input  logic [NPORT-1:0] req,
  output logic [NPORT-1:0] rstn_port,
  output logic [NPORT-1:0] ack,
  output logic             busy,
  output logic [PW-1:0]    cur_port
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (NPORT < 2 || NPORT > 16) begin : g_bad_nport
      $error("port_rst_sched: NPORT must be in 2..16");
    end
    if (HOLD_CYC < 1 || longint'(HOLD_CYC) > (longint'(1) << CW)) begin : g_bad_hold
      $error("port_rst_sched: HOLD_CYC must be in 1..2**CW");
    end
    if (SETTLE_CYC < 1 || longint'(SETTLE_CYC) > (longint'(1) << CW)) begin : g_bad_settle
      $error("port_rst_sched: SETTLE_CYC must be in 1..2**CW");
    end
  endgenerate

  // Terminal counts: the counter starts at 0, so the last cycle of a phase is
  // N-1. A parameter equal to 2**CW wraps to all-ones here, which is correct.
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] LAST_PORT   = PW'(NPORT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rst_state_e       state_reg,     state_next;
  logic [NPORT-1:0] pending_reg,   pending_next;
  logic [PW-1:0]    rr_ptr_reg,    rr_ptr_next;
  logic [CW-1:0]    cnt_reg,       cnt_next;
  logic [NPORT-1:0] rstn_port_reg, rstn_port_next;
  logic [NPORT-1:0] ack_reg,       ack_next;
  logic             busy_reg,      busy_next;
  logic [PW-1:0]    cur_port_reg,  cur_port_next;

  // Bits cleared from / forced into pending this cycle, merged with req below.
  logic [NPORT-1:0] pending_clr;
  logic [NPORT-1:0] pending_retry;

  logic             gnt_valid;
  logic [PW-1:0]    gnt_idx;

  rr_arbiter #(
    .N  (NPORT),
    .IW (PW)
  ) u_rr_arbiter (
    .pending   (pending_reg),
    .rr_ptr    (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge arstn) begin
    if (!arstn) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= '0;
      rr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      rstn_port_reg <= '1;
      ack_reg       <= '0;
      busy_reg      <= 1'b0;
      cur_port_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      rr_ptr_reg    <= rr_ptr_next;
      cnt_reg       <= cnt_next;
      rstn_port_reg <= rstn_port_next;
      ack_reg       <= ack_next;
      busy_reg      <= busy_next;
      cur_port_reg  <= cur_port_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    cnt_next       = cnt_reg;
    rstn_port_next = rstn_port_reg;
    ack_next       = '0;           // ack is a single-cycle pulse
    busy_next      = busy_reg;
    cur_port_next  = cur_port_reg;
    pending_clr    = '0;
    pending_retry  = '0;

    case (state_reg)
      ST_IDLE: begin
        if (sys_ready && gnt_valid) begin
          pending_clr[gnt_idx]    = 1'b1;
          cur_port_next           = gnt_idx;
          cnt_next                = '0;
          rstn_port_next          = '1;
          rstn_port_next[gnt_idx] = 1'b0;
          busy_next               = 1'b1;
          state_next              = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!sys_ready) begin
          // Global reset re-asserted: release the port, requeue it, no ack.
          rstn_port_next              = '1;
          pending_retry[cur_port_reg] = 1'b1;
          busy_next                   = 1'b0;
          cnt_next                    = '0;
          state_next                  = ST_IDLE;
        end else if (cnt_reg == HOLD_LAST) begin
          rstn_port_next = '1;
          cnt_next       = '0;
          state_next     = ST_SETTLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_SETTLE: begin
        if (!sys_ready) begin
          rstn_port_next              = '1;
          pending_retry[cur_port_reg] = 1'b1;
          busy_next                   = 1'b0;
          cnt_next                    = '0;
          state_next                  = ST_IDLE;
        end else if (cnt_reg == SETTLE_LAST) begin
          ack_next[cur_port_reg] = 1'b1;
          cnt_next               = '0;
          state_next             = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_DONE: begin
        // The ack has already been issued, so the sequence is complete even
        // if sys_ready drops on this cycle; just retire it.
        busy_next   = 1'b0;
        rr_ptr_next = (cur_port_reg == LAST_PORT) ? '0 : cur_port_reg + PW'(1);
        state_next  = ST_IDLE;
      end

      default: begin
        // Illegal one-hot value: return to a safe idle with all ports released.
        rstn_port_next = '1;
        busy_next      = 1'b0;
        cnt_next       = '0;
        state_next     = ST_IDLE;
      end
    endcase

    // A request landing on the same edge its bit is cleared wins, so a port
    // re-requested during its own grant is serviced again later.
    pending_next = (pending_reg & ~pending_clr) | pending_retry | req;
  end

  assign rstn_port = rstn_port_reg;
  assign ack       = ack_reg;
  assign busy      = busy_reg;
  assign cur_port  = cur_port_reg;

endmodule : port_rst_sched

// File: tb/tb_port_rst_sched.sv
// -----------------------------------------------------------------------------
// tb_port_rst_sched
//   Self-checking bench for port_rst_sched (NPORT=4, HOLD=64, SETTLE=128).
//   The reference model tracks only the serviced port and the edge at which
//   its grant happened; all expected outputs are derived from elapsed time.
// -----------------------------------------------------------------------------
module tb_port_rst_sched;

  localparam int N = 4;
  localparam int H = 64;
  localparam int S = 128;
  localparam int PERIOD = H + S + 2;

  logic         sys_clk = 1'b0;
  logic         arstn;
  logic         sys_ready;
  logic [N-1:0] req;
  logic [N-1:0] rstn_port;
  logic [N-1:0] ack;
  logic         busy;
  logic [1:0]   cur_port;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           cyc     = 0;   // index of the most recent active edge
  int           m_port  = -1;  // port being serviced, -1 when idle
  int           m_start = 0;   // edge index of the grant
  int           m_rr    = 0;
  logic [N-1:0] m_pend  = '0;

  port_rst_sched #(
    .NPORT      (N),
    .HOLD_CYC   (H),
    .SETTLE_CYC (S),
    .CW         (8)
  ) dut (
    .sys_clk   (sys_clk),
    .arstn     (arstn),
    .sys_ready (sys_ready),
    .req       (req),
    .rstn_port (rstn_port),
    .ack       (ack),
    .busy      (busy),
    .cur_port  (cur_port)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_port = -1;
    m_pend = '0;
    m_rr   = 0;
  endtask

  // Apply the scheduling rules for one active edge using the inputs presented.
  task automatic model_edge();
    int el;
    int sel;
    cyc++;
    if (m_port >= 0) begin
      el = cyc - m_start;
      if (!sys_ready && el >= 1 && el <= H + S) begin
        m_pend[m_port] = 1'b1;
        m_port = -1;
      end else if (el == H + S + 1) begin
        m_rr   = (m_port + 1) % N;
        m_port = -1;
      end
    end else if (sys_ready && m_pend != '0) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && m_pend[(m_rr + k) % N]) sel = (m_rr + k) % N;
      end
      m_pend[sel] = 1'b0;
      m_port      = sel;
      m_start     = cyc;
    end
    m_pend = m_pend | req;
  endtask

  // Expected {rstn_port, ack, busy, cur_port} after the latest edge.
  function automatic logic [10:0] exp_vec();
    logic [3:0] r;
    logic [3:0] a;
    int el;
    r = 4'hF;
    a = 4'h0;
    if (m_port >= 0) begin
      el = cyc - m_start;
      if (el < H) r[m_port] = 1'b0;
      if (el == H + S) a[m_port] = 1'b1;
      return {r, a, 1'b1, 2'(m_port)};
    end
    return {r, a, 1'b0, 2'b00};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {rstn_port, ack, busy, (busy === 1'b1) ? cur_port : 2'b00};
  endfunction

  // Called at a falling edge: present req, take one active edge, return at
  // the next falling edge with req cleared.
  task automatic tick(input logic [N-1:0] r);
    req = r;
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    req = '0;
  endtask

  task automatic apply_reset();
    arstn = 1'b0;
    req   = '0;
    repeat (2) @(negedge sys_clk);
    model_reset();
    arstn = 1'b1;
  endtask

  task automatic test_reset();
    arstn     = 1'b0;
    sys_ready = 1'b1;
    req       = '0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({rstn_port, ack, busy} !== {4'hF, 4'h0, 1'b0} || cur_port !== 2'd0) begin
      failures++;
      $display("FAIL reset_values got rstn=%b ack=%b busy=%b cur=%0d expected 1111/0000/0/0",
               rstn_port, ack, busy, cur_port);
    end
    model_reset();
    arstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick('0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
    end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    int e0, first_low, rel, ack_cyc, lowcnt, acks, curbad;
    apply_reset();
    sys_ready = 1'b1;
    tick(4'b0100);
    e0 = cyc;
    first_low = -1; rel = -1; ack_cyc = -1; lowcnt = 0; acks = 0; curbad = 0;
    for (int i = 0; i < H + S + 10; i++) begin
      tick('0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_cycle cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
      if (rstn_port === 4'b1011) lowcnt++;
      if (rstn_port[2] === 1'b0 && first_low < 0) first_low = cyc;
      if (rstn_port[2] === 1'b1 && first_low >= 0 && rel < 0) rel = cyc;
      if (ack !== 4'h0) begin
        acks++;
        ack_cyc = cyc;
      end
      if (busy === 1'b1 && cur_port !== 2'd2) curbad++;
    end
    checks++;
    if (first_low != e0 + 1) begin
      failures++;
      $display("FAIL single_latency got edge %0d expected %0d", first_low, e0 + 1);
    end
    checks++;
    if (lowcnt != H) begin
      failures++;
      $display("FAIL single_hold got %0d cycles expected %0d", lowcnt, H);
    end
    checks++;
    if (acks != 1 || ack_cyc - rel != S) begin
      failures++;
      $display("FAIL single_ack got count=%0d delay=%0d expected 1/%0d", acks, ack_cyc - rel, S);
    end
    checks++;
    if (curbad != 0) begin
      failures++;
      $display("FAIL single_cur_port got %0d bad cycles expected 0", curbad);
    end
    $display("test_single done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_simultaneous();
    int ack_p[$];
    int ack_c[$];
    int multi_low;
    apply_reset();
    sys_ready = 1'b1;
    multi_low = 0;
    tick(4'b1011);
    for (int i = 0; i < 3 * PERIOD + 10; i++) begin
      tick('0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL simul_cycle cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
      if ($countones(~rstn_port) > 1) multi_low++;
      for (int p = 0; p < N; p++) begin
        if (ack[p] === 1'b1) begin
          ack_p.push_back(p);
          ack_c.push_back(cyc);
        end
      end
    end
    checks++;
    if (ack_p.size() != 3 || ack_p[0] != 0 || ack_p[1] != 1 || ack_p[2] != 3) begin
      failures++;
      $display("FAIL simul_order got n=%0d %p expected 0,1,3", ack_p.size(), ack_p);
    end
    checks++;
    if (ack_c.size() != 3 || ack_c[1] - ack_c[0] != PERIOD || ack_c[2] - ack_c[1] != PERIOD) begin
      failures++;
      $display("FAIL simul_spacing got %p expected spacing %0d", ack_c, PERIOD);
    end
    checks++;
    if (multi_low != 0) begin
      failures++;
      $display("FAIL simul_one_low got %0d cycles with >1 port low expected 0", multi_low);
    end
    $display("test_simultaneous done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_rerequest();
    int acks1[$];
    int starts[$];
    logic prev;
    apply_reset();
    sys_ready = 1'b1;
    prev = 1'b1;
    for (int i = 0; i < 2 * PERIOD + 20; i++) begin
      tick((i == 0 || i == 11) ? 4'b0010 : 4'b0000);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rereq_cycle cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
      if (prev === 1'b1 && rstn_port[1] === 1'b0) starts.push_back(cyc);
      prev = rstn_port[1];
      if (ack[1] === 1'b1) acks1.push_back(cyc);
    end
    checks++;
    if (acks1.size() != 2) begin
      failures++;
      $display("FAIL rereq_acks got %0d expected 2", acks1.size());
    end
    checks++;
    if (starts.size() != 2 || acks1.size() < 1 || starts[1] != acks1[0] + 2) begin
      failures++;
      $display("FAIL rereq_restart got starts=%p acks=%p expected second start = first ack + 2",
               starts, acks1);
    end
    $display("test_rerequest done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_gate_abort();
    int acks0;
    apply_reset();
    sys_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick((i == 0) ? 4'b0001 : 4'b0000);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL gate_cycle cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b0 || rstn_port !== 4'hF) begin
      failures++;
      $display("FAIL gate_hold_off got busy=%b rstn=%b expected 0/1111", busy, rstn_port);
    end
    acks0 = 0;
    for (int i = 0; i < PERIOD + 40; i++) begin
      sys_ready = (i >= 11 && i < 16) ? 1'b0 : 1'b1;
      tick('0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL abort_cycle cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
      if (i == 11) begin
        checks++;
        if (rstn_port !== 4'hF || busy !== 1'b0 || ack !== 4'h0) begin
          failures++;
          $display("FAIL abort_release got rstn=%b busy=%b ack=%b expected 1111/0/0",
                   rstn_port, busy, ack);
        end
      end
      if (ack[0] === 1'b1) acks0++;
    end
    sys_ready = 1'b1;
    checks++;
    if (acks0 != 1) begin
      failures++;
      $display("FAIL abort_retry got %0d acks on port 0 expected 1", acks0);
    end
    $display("test_gate_abort done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_async_mid_settle();
    int acks;
    apply_reset();
    sys_ready = 1'b1;
    for (int i = 0; i < H + 20; i++) begin
      tick((i == 0) ? 4'b1000 : 4'b0000);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL async_pre cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
    end
    #2 arstn = 1'b0;
    #1;
    checks++;
    if (rstn_port !== 4'hF || busy !== 1'b0 || ack !== 4'h0) begin
      failures++;
      $display("FAIL async_immediate got rstn=%b busy=%b ack=%b expected 1111/0/0",
               rstn_port, busy, ack);
    end
    model_reset();
    @(negedge sys_clk);
    arstn = 1'b1;
    acks = 0;
    for (int i = 0; i < PERIOD + 60; i++) begin
      tick('0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL async_post cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
      end
      if (ack !== 4'h0) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL async_no_ack got %0d acks expected 0", acks);
    end
    $display("test_async_mid_settle done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    int low_left;
    logic [N-1:0] r;
    apply_reset();
    sys_ready = 1'b1;
    low_left  = 0;
    for (int i = 0; i < 4000; i++) begin
      if (low_left > 0) begin
        low_left--;
        sys_ready = 1'b0;
      end else begin
        sys_ready = 1'b1;
        if ($urandom_range(0, 499) == 0) low_left = $urandom_range(1, 6);
      end
      r = ($urandom_range(0, 19) == 0) ? N'($urandom_range(0, 15)) : '0;
      tick(r);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle cyc=%0d req=%b rdy=%b got=%h expected=%h",
                 cyc, r, sys_ready, obs_vec(), exp_vec());
      end
      checks++;
      if ($countones(~rstn_port) > 1) begin
        failures++;
        $display("FAIL random_one_low cyc=%0d got rstn=%b expected at most one low", cyc, rstn_port);
      end
    end
    $display("test_random done: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    arstn     = 1'b0;
    sys_ready = 1'b1;
    req       = '0;
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_simultaneous();
    test_rerequest();
    test_gate_abort();
    test_async_mid_settle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_port_rst_sched

// File: doc/port_rst_sched.md
Name: port_rst_sched

Overview:
Per-port soft-reset scheduler in the sys_clk domain, downstream of the global reset controller.
- Collects reset requests from NPORT per-port requesters, such as the CPU register block or a link-fault watchdog.
- Grants them round-robin, one port at a time.
- Drives that port's active-low reset for a fixed hold time, then waits a settle time before acknowledging.
- Keeps MAC/FIFO soft resets serialized, so no two ports re-initialize concurrently.

Parameters:
- NPORT, 4, number of ports/requesters (2..16).
- HOLD_CYC, 64, sys_clk cycles rstn_port is held low (1..2^CW).
- SETTLE_CYC, 128, sys_clk cycles after release before ack (1..2^CW).
- CW, 8, width of the shared cycle counter.

Ports:
- sys_clk, in, 1, single clock.
- arstn, in, 1, asynchronous active-low reset.
- sys_ready, in, 1, high once the global system reset has been released (rstn_sys); gates grants.
- req, in, NPORT, per-port one-cycle request pulse.
- rstn_port, out, NPORT, registered active-low per-port soft reset.
- ack, out, NPORT, one-cycle pulse when that port's sequence has completed.
- busy, out, 1, high while a sequence is in HOLD/SETTLE/DONE.
- cur_port, out, clog2(NPORT), index of the port being serviced (valid while busy).

Behaviour:
- Reset (arstn low, asynchronous):
  - state=IDLE; pending=0; rr_ptr=0; cnt=0.
  - rstn_port=all 1s; ack=0; busy=0; cur_port=0.
- Pending register:
  - A req bit sampled high sets pending[i] on that edge.
  - A request for a port already pending is merged, not queued twice.
- One-hot FSM states: IDLE(1), HOLD(2), SETTLE(4), DONE(8).
- IDLE:
  - If sys_ready=1 and pending!=0, select the first set bit searching rr_ptr, rr_ptr+1, ... with wrap.
  - On that edge: clear pending[sel]; cur_port<=sel; cnt<=0; rstn_port[sel]<=0; busy<=1; go to HOLD.
  - If sys_ready=0: stay in IDLE; requests keep latching.
- HOLD:
  - cnt increments each cycle.
  - When cnt==HOLD_CYC-1: rstn_port[cur]<=1; cnt<=0; go to SETTLE.
  - rstn_port[cur] is low for exactly HOLD_CYC cycles.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYC-1: ack[cur]<=1; go to DONE.
- DONE (one cycle):
  - ack<=0; busy<=0; rr_ptr<=(cur_port+1) mod NPORT; go to IDLE.
- Latency: req pulse at edge E0 → rstn_port low after E1 → high after E1+HOLD_CYC → ack high for the single cycle after E1+HOLD_CYC+SETTLE_CYC.
- Back-to-back throughput: one sequence per HOLD_CYC+SETTLE_CYC+2 cycles.
- Simultaneous events:
  - req for cur_port arriving on the grant edge or later re-sets pending; that port is serviced again in a later round.
  - req on the same edge the bit is cleared: set wins.
  - Multiple reqs in one cycle all latch; grants follow round-robin order from rr_ptr.
- sys_ready falls while busy (abort):
  - Next edge: rstn_port<=all 1s; pending[cur]<=1 so the port is retried; no ack; busy<=0; cnt<=0; go to IDLE.
  - rr_ptr is unchanged.
- Only one rstn_port bit is ever low at a time. Outputs are registered, with no combinational path from req.
- cnt width is CW; HOLD_CYC and SETTLE_CYC are compared against CW-bit values.
- Elaboration error if either parameter is 0 or exceeds 2^CW.

Decomposition:
- Shared package rst_pkg:
  - One-hot state constants (ST_IDLE/HOLD/SETTLE/DONE), also used by the global reset controller.
  - Default HOLD/SETTLE constants.
- One sub-module rr_arbiter:
  - Parameter N.
  - Inputs: pending, rr_ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational, reused by later port arbiters.

Test Plan:
1. Reset and idle: arstn low then high with sys_ready=1 and no req → rstn_port=4'b1111, ack=0, busy=0 indefinitely.
2. Single request: req=4'b0100 pulse at E0 → rstn_port=4'b1011 for exactly 64 cycles from E1; ack[2] single pulse 128 cycles after release; cur_port=2 while busy.
3. Simultaneous requests: req=4'b1011 at rr_ptr=0 → service order 0,1,3; never two rstn_port bits low; three acks, each 194 cycles apart.
4. Re-request during service: req[1] during port 1 HOLD → ack[1] twice; second sequence starts one cycle after DONE.
5. Gating and abort: sys_ready=0 with req[0] → no grant until sys_ready rises. Then drop sys_ready at HOLD cycle 10 → rstn_port returns to all 1s next edge, no ack; port 0 is re-serviced fully after sys_ready returns.
6. Async reset mid-SETTLE: arstn low → rstn_port all 1s and busy=0 immediately (no clock edge needed); pending cleared, no ack after release.
